// File: rtl/execute_cc_stage_pkg.sv
// Shared Y86-64 definitions for the execute/condition-code stage: instruction
// codes, ALU operations, jump/cmov conditions and the condition-code bundle.
package execute_cc_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE_ID = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/execute_cc_stage_if.sv
// E-register fields into the execute stage and registered M-stage fields out.
interface execute_cc_stage_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [DATA_W-1:0] E_valA;
  logic [DATA_W-1:0] E_valB;
  logic [DATA_W-1:0] E_valC;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;

  logic [3:0]        M_icode;
  logic              M_cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;

  modport master (
    output E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_cc_stage_cond_eval.sv
// Jump / conditional-move predicate from the registered condition codes.
module cond_eval
  import execute_cc_stage_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       ZF,
  input  logic       SF,
  input  logic       OF,
  output logic       cnd
);

  logic w_lt;

  assign w_lt = SF ^ OF;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = w_lt | ZF;
      C_L:     cnd = w_lt;
      C_E:     cnd = ZF;
      C_NE:    cnd = ~ZF;
      C_GE:    cnd = ~w_lt;
      C_G:     cnd = ~w_lt & ~ZF;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes and the M
// pipeline register, with stall/bubble control.
module execute_cc_stage
  import execute_cc_stage_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = RNONE_ID
) (
  input  logic              clk,
  input  logic              rst_n,
  execute_cc_stage_if.slave e_if,
  input  logic              M_stall,
  input  logic              M_bubble,
  input  logic              cc_inhibit,
  output logic              ZF,
  output logic              SF,
  output logic              OF,
  output logic              e_cnd
);

  localparam logic signed [DATA_W-1:0] K_EIGHT = DATA_W'(8);

  function automatic logic signed [DATA_W-1:0] alu_f(
    input alu_op_e                  op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      ALU_ADD: return b + a;
      ALU_SUB: return b - a;
      ALU_AND: return b & a;
      default: return b ^ a;
    endcase
  endfunction

  // Overflow judged on sign bits only; logical ops never overflow.
  function automatic logic ovf_f(
    input alu_op_e                  op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] res
  );
    case (op)
      ALU_ADD: return (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: return (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != b[DATA_W-1]);
      default: return 1'b0;
    endcase
  endfunction

  logic signed [DATA_W-1:0] w_aluA_p0;
  logic signed [DATA_W-1:0] w_aluB_p0;
  logic signed [DATA_W-1:0] w_alu_res_p0;
  alu_op_e                  w_op_p0;
  cc_t                      w_cc_next_p0;
  logic                     w_cc_we_p0;
  logic                     w_cnd_p0;
  logic [3:0]               w_dstE_p0;

  cc_t                      r_cc;
  logic [3:0]               r_m_icode_p1;
  logic                     r_m_cnd_p1;
  logic [DATA_W-1:0]        r_m_valE_p1;
  logic [DATA_W-1:0]        r_m_valA_p1;
  logic [3:0]               r_m_dstE_p1;
  logic [3:0]               r_m_dstM_p1;

  // Stage 0: operand select, ALU and condition evaluation (combinational).
  always_comb begin
    w_aluA_p0 = '0;
    case (e_if.E_icode)
      IRRMOVQ, IOPQ:             w_aluA_p0 = $signed(e_if.E_valA);
      IIRMOVQ, IRMMOVQ, IMRMOVQ: w_aluA_p0 = $signed(e_if.E_valC);
      ICALL, IPUSHQ:             w_aluA_p0 = -K_EIGHT;
      IRET, IPOPQ:               w_aluA_p0 = K_EIGHT;
      default:                   w_aluA_p0 = '0;
    endcase
  end

  always_comb begin
    w_aluB_p0 = '0;
    case (e_if.E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ:
               w_aluB_p0 = $signed(e_if.E_valB);
      default: w_aluB_p0 = '0;
    endcase
  end

  assign w_op_p0      = (e_if.E_icode == IOPQ) ? alu_op_e'(e_if.E_ifun[1:0]) : ALU_ADD;
  assign w_alu_res_p0 = alu_f(w_op_p0, w_aluA_p0, w_aluB_p0);

  assign w_cc_next_p0 = '{zf: (w_alu_res_p0 == '0),
                          sf: w_alu_res_p0[DATA_W-1],
                          of: ovf_f(w_op_p0, w_aluA_p0, w_aluB_p0, w_alu_res_p0)};
  assign w_cc_we_p0   = (e_if.E_icode == IOPQ) && !cc_inhibit && !M_stall;

  cond_eval u_cond_eval (
    .ifun (e_if.E_ifun),
    .ZF   (r_cc.zf),
    .SF   (r_cc.sf),
    .OF   (r_cc.of),
    .cnd  (w_cnd_p0)
  );

  // A cmov whose condition fails must not write its destination.
  assign w_dstE_p0 = ((e_if.E_icode == IRRMOVQ) && !w_cnd_p0) ? RNONE : e_if.E_dstE;

  // Stage 1: condition codes and M pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_cc_we_p0) begin
      r_cc <= w_cc_next_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_icode_p1 <= INOP;
      r_m_cnd_p1   <= 1'b0;
      r_m_valE_p1  <= '0;
      r_m_valA_p1  <= '0;
      r_m_dstE_p1  <= RNONE;
      r_m_dstM_p1  <= RNONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        r_m_icode_p1 <= INOP;
        r_m_cnd_p1   <= 1'b0;
        r_m_valE_p1  <= '0;
        r_m_valA_p1  <= '0;
        r_m_dstE_p1  <= RNONE;
        r_m_dstM_p1  <= RNONE;
      end else begin
        r_m_icode_p1 <= e_if.E_icode;
        r_m_cnd_p1   <= w_cnd_p0;
        r_m_valE_p1  <= w_alu_res_p0;
        r_m_valA_p1  <= e_if.E_valA;
        r_m_dstE_p1  <= w_dstE_p0;
        r_m_dstM_p1  <= e_if.E_dstM;
      end
    end
  end

  assign e_if.M_icode = r_m_icode_p1;
  assign e_if.M_cnd   = r_m_cnd_p1;
  assign e_if.M_valE  = r_m_valE_p1;
  assign e_if.M_valA  = r_m_valA_p1;
  assign e_if.M_dstE  = r_m_dstE_p1;
  assign e_if.M_dstM  = r_m_dstM_p1;

  assign ZF    = r_cc.zf;
  assign SF    = r_cc.sf;
  assign OF    = r_cc.of;
  assign e_cnd = w_cnd_p0;

endmodule

// File: doc/execute_cc_stage.md
EXECUTE_CC_STAGE -- requirements
Module: execute_cc_stage

Interface
REQ-001 Parameter: DATA_W, 64, ALU operand/result width.
REQ-002 Parameter: RNONE, 4'hF, register ID meaning "no register".
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 E_icode  input  4  instruction code from the E pipeline register.
REQ-006 E_ifun  input  4  function code: ALU op for OPq, condition for jXX/cmovXX.
REQ-007 E_valA  input  DATA_W  operand A, also forwarded to M as M_valA.
REQ-008 E_valB  input  DATA_W  operand B.
REQ-009 E_valC  input  DATA_W  immediate/displacement.
REQ-010 E_dstE, E_dstM  input  4 each  destination register IDs.
REQ-011 M_stall  input  1  hold the M register.
REQ-012 M_bubble  input  1  load a NOP into the M register.
REQ-013 cc_inhibit  input  1  exception pending in M/W; blocks CC update.
REQ-014 M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  output  4/1/DATA_W/DATA_W/4/4  registered M-stage fields.
REQ-015 ZF, SF, OF  output  1 each  registered condition codes.
REQ-016 e_cnd  output  1  combinational condition result for the current E instruction.

Function
REQ-017 aluA SHALL be E_valA for RRMOVQ(2)/OPq(6); E_valC for IRMOVQ(3)/RMMOVQ(4)/MRMOVQ(5); -8 for CALL(8)/PUSHQ(A); +8 for RET(9)/POPQ(B); 0 otherwise.
REQ-018 aluB SHALL be E_valB for 4,5,6,8,9,A,B; 0 for 2,3; 0 otherwise.
REQ-019 The ALU SHALL compute aluB op aluA: ifun 0 add, 1 sub (aluB-aluA), 2 and, 3 xor; non-OPq instructions use add.
REQ-020 Arithmetic SHALL be two's complement modulo 2^DATA_W; carry-out is discarded.
REQ-021 OF (add) SHALL be set when both operands have equal sign and the result sign differs; OF (sub) SHALL be set when operand signs differ and the result sign differs from aluB's; OF for and/xor SHALL be 0.
REQ-022 CC (ZF = result==0, SF = result[DATA_W-1], OF) SHALL update only when E_icode==6, cc_inhibit==0 and M_stall==0; otherwise CC SHALL hold.
REQ-023 e_cnd SHALL use the current registered CC: ifun 0 1, 1 (SF^OF)|ZF, 2 SF^OF, 3 ZF, 4 !ZF, 5 !(SF^OF), 6 !(SF^OF)&!ZF; ifun>6 SHALL yield 0.
REQ-024 An OPq SHALL NOT see its own CC update; the next instruction SHALL see it (one-cycle CC latency).
REQ-025 For cmovXX (icode 2) with e_cnd==0, M_dstE SHALL be RNONE; otherwise M_dstE = E_dstE.
REQ-026 The M register SHALL load {E_icode, e_cnd, ALU result, E_valA, dstE per REQ-025, E_dstM} each cycle with M_stall==0 and M_bubble==0 (one-cycle latency).
REQ-027 M_bubble==1 (M_stall==0) SHALL load NOP: M_icode=1, M_cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
REQ-028 M_stall==1 SHALL hold M and CC; M_stall SHALL take priority over M_bubble when both are asserted.
REQ-029 Reset asserted mid-operation SHALL discard in-flight state immediately, independent of clk.

Reset
REQ-030 While rst_n==0, M SHALL hold the NOP values of REQ-027.
REQ-031 While rst_n==0, CC SHALL be ZF=1, SF=0, OF=0.
REQ-032 The first rising edge after rst_n deasserts SHALL behave as normal operation.

Structure
REQ-033 Icode constants (INOP..IPOPQ), ALU op codes, condition codes and RNONE SHALL live in the shared Y86 package.
REQ-034 Condition evaluation (REQ-023) SHALL be the sub-module cond_eval (inputs ifun, ZF, SF, OF; output cnd).
REQ-035 The ALU and CC logic SHALL remain in execute_cc_stage.

Verification
REQ-036 OPq sub, aluB=5, aluA=5 -> next cycle M_valE=0 and ZF=1, SF=0, OF=0.
REQ-037 OPq add, 0x7FFF_FFFF_FFFF_FFFF + 1 -> M_valE=0x8000_0000_0000_0000, SF=1, OF=1, ZF=0.
REQ-038 CC ZF=1, then cmovne (ifun 4) with E_dstE=3 -> M_dstE=RNONE, M_cnd=0; cmove (ifun 3) -> M_dstE=3, M_cnd=1.
REQ-039 OPq with cc_inhibit=1 -> CC unchanged; M_valE still loaded.
REQ-040 M_stall=1 and M_bubble=1 together for 2 cycles -> M and CC hold; then M_bubble alone -> M_icode=1, M_dstE=M_dstM=0xF.
REQ-041 PUSHQ with E_valB=0x100 -> M_valE=0xF8; rst_n pulled low between edges -> outputs take reset values immediately.
